huffman_decoder: RTL
====================

// Module: huffman_decoder
// PURPOSE
//  Serial Huffman decoder: the receive-side counterpart of the weight-sort/Huffman-encode path.
//  - Loads an NUM_CHAR-entry code table (code, length per character index).
//  - Consumes a 1-bit/cycle code stream and emits one character index per completed codeword.
//  - Flags malformed streams.
// PARAMETERS
//  NUM_CHAR  8  number of table entries / characters (3..8), loaded in index order 0..NUM_CHAR-1
//  CODE_MAX  7  maximum codeword length in bits (NUM_CHAR-1 for a full Huffman tree)
//  LEN_W     3  width of length fields, = $clog2(CODE_MAX+1)
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  tbl_valid  in   1         table entry strobe; accepted only in IDLE/LOAD
//  tbl_code   in   CODE_MAX  codeword, right-aligned; bit [len-1] is transmitted first
//  tbl_len    in   LEN_W     codeword length; 0 = unused entry, never matches
//  bit_valid  in   1         stream bit strobe; accepted only in DECODE
//  bit_in     in   1         stream bit
//  bit_last   in   1         qualifies bit_valid; marks final bit of the stream
//  busy       out  1         high in LOAD and DECODE
//  out_valid  out  1         one-cycle pulse, decoded character present
//  out_char   out  4         decoded character index, zero-extended
//  out_err    out  1         one-cycle pulse, stream error
//  out_done   out  1         one-cycle pulse, stream finished cleanly
// BEHAVIOUR
//  Reset: async on rst_n low.
//  - All outputs 0; FSM=IDLE; acc, len_cnt, load counter 0.
//  - All table lengths 0 (table invalid).
//  FSM: IDLE -> LOAD -> DECODE -> IDLE.
//  - IDLE: tbl_valid stores entry 0, goes to LOAD with load counter 1. bit_valid ignored.
//  - LOAD: each tbl_valid stores entry[cnt] and increments cnt.
//    Cycles without tbl_valid are allowed (gaps); no timeout.
//    The cycle storing entry NUM_CHAR-1 moves to DECODE.
//  - DECODE: tbl_valid ignored. On bit_valid:
//    acc_n = {acc[CODE_MAX-2:0], bit_in}; len_n = len_cnt + 1.
//  Match (combinational on acc_n/len_n): entry i matches if
//  - tbl_len[i] == len_n, and
//  - tbl_code[i][len_n-1:0] == acc_n[len_n-1:0].
//  - Multiple matches (non-prefix-free table): lowest index wins.
//  Per accepted bit, next edge:
//  - Match: out_valid=1, out_char=i, acc/len_cnt cleared. Latency = 1 cycle after the final code bit.
//  - No match and len_n == CODE_MAX: out_err=1, acc/len_cnt cleared, decoding continues with the next bit.
//  - No match and len_n < CODE_MAX: acc=acc_n, len_cnt=len_n, no pulse.
//  bit_last with bit_valid, same edge, in addition to the above:
//  - Match: out_valid and out_done both pulse; FSM -> IDLE.
//  - No match: out_err pulses (once, even if len_n==CODE_MAX); out_done stays 0; FSM -> IDLE.
//  - Returning to IDLE clears acc/len_cnt. The table is retained but must be reloaded before the next stream.
//  bit_last without bit_valid is ignored.
//  out_char holds its last value when out_valid=0. out_err and out_valid are never both high except:
//  - never; a match always suppresses err.
//  Back-to-back bits every cycle are supported, giving at most one out_valid per cycle.
//  No backpressure exists.
//  rst_n assertion mid-LOAD or mid-DECODE aborts immediately:
//  - no out_done/out_err is produced;
//  - the table is invalidated.
// TESTING (table T: idx0 "0"/1, idx1 "10"/2, idx2 "110"/3, idx3 "1110"/4, idx4 "11110"/5,
//          idx5 "111110"/6, idx6 "1111110"/7, idx7 "1111111"/7)
//  1. Load T, stream 0,1,0,1,1,1,1,1,1,1(last), one bit per cycle.
//     -> out_char 0,1,7 each 1 cycle after its final bit; out_done with the 7; busy falls next cycle.
//  2. Load T with 2 idle gaps between entries 3 and 4, stream 1,1,0(last).
//     -> single out_valid out_char=2 + out_done.
//  3. Table: all len 7, idx0 code 7'h7F, others 7'h00; stream 1,0,1,1,1,1,1, then 0(last).
//     -> out_err after 7th bit, no out_valid, decoding continues; 8th bit gives out_err, no out_done.
//  4. Load T, stream 1,1(last).
//     -> out_err pulse, out_done=0, FSM IDLE; a following bit_valid is ignored.
//  5. Load T, stream 1,1, then rst_n low async mid-codeword.
//     -> all outputs 0 immediately; no out_valid/out_err after release.
//  6. bit_valid in IDLE and tbl_valid in DECODE.
//     -> both ignored (no pulses, table unchanged); duplicate-code table resolves to lowest index.

Source files
------------

// File: rtl/huffman_decoder_if.sv
// Handshake bundle for the serial Huffman decoder: table load, bit stream in, decode events out.
interface huffman_decoder_if #(
  parameter int CODE_MAX = 7,
  parameter int LEN_W    = $clog2(CODE_MAX + 1)
);
  logic                tbl_valid;
  logic [CODE_MAX-1:0] tbl_code;
  logic [LEN_W-1:0]    tbl_len;
  logic                bit_valid;
  logic                bit_in;
  logic                bit_last;
  logic                busy;
  logic                out_valid;
  logic [3:0]          out_char;
  logic                out_err;
  logic                out_done;

  modport master (
    output tbl_valid, tbl_code, tbl_len, bit_valid, bit_in, bit_last,
    input  busy, out_valid, out_char, out_err, out_done
  );

  modport slave (
    input  tbl_valid, tbl_code, tbl_len, bit_valid, bit_in, bit_last,
    output busy, out_valid, out_char, out_err, out_done
  );
endinterface

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: loads a code table, then turns a 1-bit/cycle stream into
// character indices, flagging codewords that never match.
//
//   state  | meaning
//   IDLE   | waiting for table entry 0; stream bits ignored
//   LOAD   | storing table entries 1..NUM_CHAR-1 in order
//   DECODE | shifting in stream bits and matching against the table
module huffman_decoder #(
  parameter int NUM_CHAR = 8,
  parameter int CODE_MAX = 7,
  parameter int LEN_W    = $clog2(CODE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  huffman_decoder_if.slave hd
);
  localparam int CNT_W = $clog2(NUM_CHAR);

  typedef enum logic [1:0] {IDLE, LOAD, DECODE} state_t;

  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [NUM_CHAR-1:0][CODE_MAX-1:0] code_q, code_d;
  logic [NUM_CHAR-1:0][LEN_W-1:0]    len_q, len_d;
  // Only CODE_MAX-1 bits are ever kept: a full-length codeword always clears.
  logic [CODE_MAX-2:0]               acc_q, acc_d;
  logic [LEN_W-1:0]                  len_cnt_q, len_cnt_d;
  logic                              out_valid_q, out_valid_d;
  logic [3:0]                        out_char_q, out_char_d;
  logic                              out_err_q, out_err_d;
  logic                              out_done_q, out_done_d;

  logic [CODE_MAX-1:0] acc_n;
  logic [CODE_MAX-1:0] mask_n;
  logic [LEN_W-1:0]    len_n;
  logic                hit;
  logic [3:0]          hit_idx;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    acc_n   = {acc_q, hd.bit_in};
    len_n   = len_cnt_q + 1'b1;
    mask_n  = ~({CODE_MAX{1'b1}} << len_n);
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CHAR - 1; i >= 0; i--) begin
      if ((len_q[i] == len_n) && (((code_q[i] ^ acc_n) & mask_n) == '0)) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    len_d       = len_q;
    acc_d       = acc_q;
    len_cnt_d   = len_cnt_q;
    out_valid_d = 1'b0;
    out_char_d  = out_char_q;
    out_err_d   = 1'b0;
    out_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hd.tbl_valid) begin
          code_d[0] = hd.tbl_code;
          len_d[0]  = hd.tbl_len;
          cnt_d     = CNT_W'(1);
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (hd.tbl_valid) begin
          code_d[cnt_q] = hd.tbl_code;
          len_d[cnt_q]  = hd.tbl_len;
          cnt_d         = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_CHAR - 1)) begin
            cnt_d   = '0;
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        if (hd.bit_valid) begin
          if (hit) begin
            out_valid_d = 1'b1;
            out_char_d  = hit_idx;
            out_done_d  = hd.bit_last;
            acc_d       = '0;
            len_cnt_d   = '0;
          end else if (hd.bit_last || (len_n == LEN_W'(CODE_MAX))) begin
            out_err_d = 1'b1;
            acc_d     = '0;
            len_cnt_d = '0;
          end else begin
            acc_d     = acc_n[CODE_MAX-2:0];
            len_cnt_d = len_n;
          end
          if (hd.bit_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      len_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_err_q   <= 1'b0;
      out_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      len_cnt_q   <= len_cnt_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_err_q   <= out_err_d;
      out_done_q  <= out_done_d;
    end
  end

  assign hd.busy      = (state_q != IDLE);
  assign hd.out_valid = out_valid_q;
  assign hd.out_char  = out_char_q;
  assign hd.out_err   = out_err_q;
  assign hd.out_done  = out_done_q;
endmodule
